// File: rtl/tff_bank_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tff_bank_sequencer: drives the T inputs of an external T-FF bank so     |
// | that it behaves as a loadable up/down counter.  Rev 1.0                 |
// +------------------------------------------------------------------------+
module tff_bank_sequencer #(
  parameter int W     = 4,
  parameter int CNT_W = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                cmd_valid,
  output logic                                cmd_ready,
  input  logic [1:0]                          cmd_op,
  input  logic [((W > CNT_W) ? W : CNT_W)-1:0] cmd_arg,
  input  logic                                abort,
  input  logic [W-1:0]                        q_vec,
  output logic [W-1:0]                        t_vec,
  output logic                                busy,
  output logic                                done,
  output logic                                wrapped
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_APPLY = 2'd1,
    S_COUNT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] OP_CLEAR = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;

  state_t           state_q, state_d;
  logic             down_q, down_d;
  logic [W-1:0]     target_q, target_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic             wrap_q, wrap_d;
  logic             done_q, done_d;
  logic             wrapped_q, wrapped_d;
  logic             busy_q, busy_d;
  logic             cmd_ready_q, cmd_ready_d;

  // Toggle vectors that step the bank by +1 / -1 from its current value.
  logic [W-1:0] up_t;
  logic [W-1:0] dn_t;

  assign up_t[0] = 1'b1;
  assign dn_t[0] = 1'b1;

  for (genvar i = 1; i < W; i++) begin : g_step
    assign up_t[i] = &q_vec[i-1:0];
    assign dn_t[i] = ~|q_vec[i-1:0];
  end

  always_comb begin
    state_d     = state_q;
    down_d      = down_q;
    target_d    = target_q;
    remaining_d = remaining_q;
    wrap_d      = wrap_q;
    t_vec       = '0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          down_d      = cmd_op[0];
          wrap_d      = 1'b0;
          remaining_d = cmd_arg[CNT_W-1:0];
          target_d    = (cmd_op == OP_CLEAR) ? '0 : cmd_arg[W-1:0];
          if ((cmd_op == OP_CLEAR) || (cmd_op == OP_LOAD)) begin
            state_d = S_APPLY;
          end else if (cmd_arg[CNT_W-1:0] == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_COUNT;
          end
        end
      end

      S_APPLY: begin
        t_vec   = q_vec ^ target_q;
        state_d = S_DONE;
      end

      S_COUNT: begin
        // Abort wins over the final step: no toggle in the aborted cycle.
        if (abort) begin
          state_d = S_DONE;
        end else begin
          t_vec       = down_q ? dn_t : up_t;
          remaining_d = remaining_q - CNT_W'(1);
          if (down_q ? ~|q_vec : &q_vec) begin
            wrap_d = 1'b1;
          end
          if (remaining_q == CNT_W'(1)) begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    done_d      = (state_d == S_DONE);
    wrapped_d   = (state_d == S_DONE) && wrap_d;
    busy_d      = (state_d != S_IDLE);
    cmd_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      down_q      <= 1'b0;
      target_q    <= '0;
      remaining_q <= '0;
      wrap_q      <= 1'b0;
      done_q      <= 1'b0;
      wrapped_q   <= 1'b0;
      busy_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      down_q      <= down_d;
      target_q    <= target_d;
      remaining_q <= remaining_d;
      wrap_q      <= wrap_d;
      done_q      <= done_d;
      wrapped_q   <= wrapped_d;
      busy_q      <= busy_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign wrapped   = wrapped_q;

endmodule
`default_nettype wire

// File: tb/tb_tff_bank_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_tff_bank_sequencer: bench for tff_bank_sequencer with a W=4 T-FF     |
// | bank model and a done-time scoreboard.  Rev 1.0                         |
// +------------------------------------------------------------------------+
module tb_tff_bank_sequencer;

  localparam logic [1:0] OP_CLEAR = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_UP    = 2'b10;
  localparam logic [1:0] OP_DOWN  = 2'b11;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_arg;
  logic       abort;
  logic [3:0] q_vec;
  logic [3:0] t_vec;
  logic       busy;
  logic       done;
  logic       wrapped;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [3:0] q;
    logic       w;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    logic [1:0] op;
    logic [7:0] arg;
    logic [3:0] exp_q;
    logic       exp_w;
    int         exp_busy;
  } vec_t;

  vec_t tbl[11];

  tff_bank_sequencer #(.W(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_arg   (cmd_arg),
    .abort     (abort),
    .q_vec     (q_vec),
    .t_vec     (t_vec),
    .busy      (busy),
    .done      (done),
    .wrapped   (wrapped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // JK flops with J=K=T: each set bit of t_vec toggles its flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_vec <= '0;
    else     q_vec <= q_vec ^ t_vec;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard consumer: every done pulse must match the oldest accepted command.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_q_vec", 32'(q_vec), 32'(e.q));
        chk("done_wrapped", 32'(wrapped), 32'(e.w));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns in the first cycle after the accepting edge.
  task automatic send(input logic [1:0] op, input logic [7:0] arg,
                      input logic [3:0] eq, input logic ew);
    int n;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    n = 0;
    while (!cmd_ready && n < 50) begin
      tick();
      n++;
    end
    if (!cmd_ready) chk("handshake_timeout", 32'(0), 32'(1));
    sb.push_back('{q: eq, w: ew});
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 400) begin
      tick();
      n++;
    end
    if (busy) chk("idle_timeout", 32'(0), 32'(1));
  endtask

  initial begin
    int nb;
    int n;

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_arg = 8'h00; abort = 1'b0;

    tbl[0]  = '{op: OP_LOAD,  arg: 8'h0D, exp_q: 4'b1101, exp_w: 1'b0, exp_busy: 2};
    tbl[1]  = '{op: OP_UP,    arg: 8'd5,  exp_q: 4'b0010, exp_w: 1'b1, exp_busy: 6};
    tbl[2]  = '{op: OP_LOAD,  arg: 8'h03, exp_q: 4'b0011, exp_w: 1'b0, exp_busy: 2};
    tbl[3]  = '{op: OP_DOWN,  arg: 8'd3,  exp_q: 4'b0000, exp_w: 1'b0, exp_busy: 4};
    tbl[4]  = '{op: OP_DOWN,  arg: 8'd1,  exp_q: 4'b1111, exp_w: 1'b1, exp_busy: 2};
    tbl[5]  = '{op: OP_UP,    arg: 8'd0,  exp_q: 4'b1111, exp_w: 1'b0, exp_busy: 1};
    tbl[6]  = '{op: OP_LOAD,  arg: 8'h06, exp_q: 4'b0110, exp_w: 1'b0, exp_busy: 2};
    tbl[7]  = '{op: OP_CLEAR, arg: 8'hFF, exp_q: 4'b0000, exp_w: 1'b0, exp_busy: 2};
    tbl[8]  = '{op: OP_UP,    arg: 8'd16, exp_q: 4'b0000, exp_w: 1'b1, exp_busy: 17};
    tbl[9]  = '{op: OP_DOWN,  arg: 8'd255, exp_q: 4'b0001, exp_w: 1'b1, exp_busy: 256};
    tbl[10] = '{op: OP_LOAD,  arg: 8'h5A, exp_q: 4'b1010, exp_w: 1'b0, exp_busy: 2};

    // Reset state
    #3;
    chk("rst_t_vec", 32'(t_vec), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_wrapped", 32'(wrapped), 32'(0));
    chk("rst_cmd_ready", 32'(cmd_ready), 32'(1));
    tick(); tick();
    rst = 1'b0;
    tick();

    // LOAD 1010 cycle by cycle
    send(OP_LOAD, 8'h0A, 4'b1010, 1'b0);
    chk("load_apply_t_vec", 32'(t_vec), 32'(4'b1010));
    chk("load_apply_busy", 32'(busy), 32'(1));
    tick();
    chk("load_q_vec", 32'(q_vec), 32'(4'b1010));
    chk("load_done", 32'(done), 32'(1));
    chk("load_wrapped", 32'(wrapped), 32'(0));
    chk("load_done_t_vec", 32'(t_vec), 32'(0));
    chk("load_done_ready", 32'(cmd_ready), 32'(0));
    tick();
    chk("load_ready_back", 32'(cmd_ready), 32'(1));
    chk("load_busy_low", 32'(busy), 32'(0));

    // Table-driven commands chained from the previous final value
    for (int i = 0; i < 11; i++) begin
      send(tbl[i].op, tbl[i].arg, tbl[i].exp_q, tbl[i].exp_w);
      if (tbl[i].op == OP_UP && tbl[i].arg == 8'd0)
        chk("zero_count_t_vec", 32'(t_vec), 32'(0));
      wait_idle(nb);
      chk($sformatf("vec%0d_busy_cycles", i), 32'(nb), 32'(tbl[i].exp_busy));
      chk($sformatf("vec%0d_final_q", i), 32'(q_vec), 32'(tbl[i].exp_q));
      chk($sformatf("vec%0d_ready", i), 32'(cmd_ready), 32'(1));
    end

    // COUNT_UP 10 from 0000, abort in the 4th COUNT cycle
    send(OP_CLEAR, 8'h00, 4'b0000, 1'b0);
    wait_idle(nb);
    send(OP_UP, 8'd10, 4'b0011, 1'b0);
    chk("up_c1_t_vec", 32'(t_vec), 32'(4'b0001));
    tick();
    chk("up_c2_t_vec", 32'(t_vec), 32'(4'b0011));
    tick();
    tick();
    abort = 1'b1;
    #1;
    chk("abort_t_vec", 32'(t_vec), 32'(0));
    tick();
    abort = 1'b0;
    chk("abort_done", 32'(done), 32'(1));
    chk("abort_q_vec", 32'(q_vec), 32'(4'b0011));
    wait_idle(nb);
    send(OP_LOAD, 8'h09, 4'b1001, 1'b0);
    wait_idle(nb);
    chk("post_abort_load_q", 32'(q_vec), 32'(4'b1001));

    // cmd_valid held while busy is only accepted after DONE
    send(OP_UP, 8'd3, 4'b1100, 1'b0);
    cmd_valid = 1'b1;
    cmd_op    = OP_LOAD;
    cmd_arg   = 8'h07;
    sb.push_back('{q: 4'b0111, w: 1'b0});
    n = 0;
    while (!cmd_ready && n < 50) begin
      tick();
      n++;
    end
    chk("held_wait_cycles", 32'(n), 32'(4));
    chk("held_q_before", 32'(q_vec), 32'(4'b1100));
    tick();
    cmd_valid = 1'b0;
    chk("held_apply_t_vec", 32'(t_vec), 32'(4'b1011));
    wait_idle(nb);
    chk("held_final_q", 32'(q_vec), 32'(4'b0111));

    // Reset pulsed in the middle of a COUNT
    send(OP_UP, 8'd10, 4'b0001, 1'b0);
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_t_vec", 32'(t_vec), 32'(0));
    chk("midrst_busy", 32'(busy), 32'(0));
    chk("midrst_done", 32'(done), 32'(0));
    chk("midrst_ready", 32'(cmd_ready), 32'(1));
    sb.delete();
    tick();
    tick();
    rst = 1'b0;
    tick();
    tick();
    tick();
    chk("postrst_ready", 32'(cmd_ready), 32'(1));
    chk("postrst_busy", 32'(busy), 32'(0));
    chk("postrst_q", 32'(q_vec), 32'(0));
    send(OP_LOAD, 8'h05, 4'b0101, 1'b0);
    wait_idle(nb);
    tick();
    chk("sb_empty", 32'(sb.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tff_bank_sequencer.md
Name: tff_bank_sequencer

Overview:
- Command-driven controller that sequences the T inputs of an external bank of W toggle flip-flops (T-FF built from JK, q/qb outputs) sharing the same clk/rst.
- Turns load/clear/count-up/count-down commands into per-bit toggle vectors, using the bank's fed-back q vector.
- The bank then behaves as a loadable up/down counter with a valid/ready command port, done/wrap status and abort.

Parameters:
- W, 4, width of the controlled T-FF bank (number of bits).
- CNT_W, 8, width of the step-count argument for count commands.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  controller can accept a command.
- cmd_op  input  2  00 CLEAR, 01 LOAD, 10 COUNT_UP, 11 COUNT_DOWN.
- cmd_arg  input  max(W,CNT_W)  LOAD: target value (low W bits); COUNT: step count (low CNT_W bits); CLEAR: ignored.
- abort  input  1  terminate an in-progress COUNT.
- q_vec  input  W  current q outputs of the T-FF bank.
- t_vec  output  W  T inputs to the bank; a bit set causes that flop to toggle at the next rising edge.
- busy  output  1  high whenever the state is not IDLE.
- done  output  1  one-cycle completion pulse.
- wrapped  output  1  valid with done; high if the command wrapped the counter.

Behaviour:
- States: IDLE, APPLY, COUNT, DONE.
- Reset (async, immediate): state=IDLE, t_vec=0, done=0, wrapped=0, busy=0, cmd_ready=1. All internal registers are cleared.
- Reset mid-operation abandons the command with no done pulse. The bank's own rst clears q_vec in parallel.
- IDLE:
  - cmd_ready=1, t_vec=0.
  - A handshake (cmd_valid & cmd_ready at a rising edge) latches op, target and count, and clears the wrap flag.
  - CLEAR latches target=0, then ->APPLY. LOAD ->APPLY.
  - COUNT_UP/DOWN with count!=0 ->COUNT. Count==0 ->DONE directly, with no toggles and wrapped=0.
- APPLY:
  - Lasts exactly one cycle. t_vec = q_vec XOR target (combinational from q_vec).
  - After the edge, q_vec==target. Next state is DONE.
- COUNT:
  - t_vec is combinational from q_vec.
  - UP: t_vec[0]=1, t_vec[i]=&q_vec[i-1:0].
  - DOWN: t_vec[0]=1, t_vec[i]=&~q_vec[i-1:0].
  - Each cycle: remaining decrements, and the wrap flag is set if UP with q_vec all-ones or DOWN with q_vec all-zeros.
  - ->DONE after the cycle in which remaining==1. There are exactly count toggle cycles.
  - Wrap-around is modulo 2^W. No saturation.
- abort:
  - Sampled only in COUNT.
  - If abort=1 in a COUNT cycle, that cycle's t_vec is forced to 0 (no step) and the next state is DONE.
  - Abort has priority over the final step. abort is ignored in IDLE, APPLY and DONE.
- DONE:
  - One cycle: done=1, wrapped=wrap flag, t_vec=0, cmd_ready=0.
  - ->IDLE. A new command can be accepted the following cycle.
- Latency: handshake at edge k.
  - LOAD/CLEAR: q_vec updated at edge k+1, done high in cycle k+1..k+2.
  - COUNT n: final q_vec at edge k+n, done in the following cycle.
- cmd_valid while busy: not accepted; the command is held by the requester (cmd_ready=0).
- busy=1 in APPLY, COUNT, DONE.
- done and wrapped are registered outputs. t_vec is combinational from state and q_vec, and is 0 outside APPLY/COUNT.
- Arithmetic: remaining is CNT_W bits, decrement only. Target uses the low W bits of cmd_arg.

Test Plan:
- The bench models a W=4 T-FF bank on clk/rst.
- Reset then LOAD 4'b1010 -> t_vec=1010 for one cycle; q_vec=1010 after the next edge; done pulse one cycle later with wrapped=0; cmd_ready back to 1.
- From q=1101, COUNT_UP arg=5 -> q sequence 1110,1111,0000,0001,0010; done with wrapped=1; busy high for 6 cycles.
- From q=0011, COUNT_DOWN arg=3 -> q 0010,0001,0000; wrapped=0. Then COUNT_DOWN arg=1 -> q=1111, wrapped=1.
- COUNT_UP arg=0 -> no t_vec activity, done the cycle after the handshake, q unchanged. CLEAR from q=0110 -> t_vec=0110, q=0000.
- COUNT_UP arg=10 from 0000 with abort asserted in the 4th COUNT cycle -> q stops at 0011; done next cycle; subsequent LOAD accepted.
- rst pulsed mid-COUNT -> t_vec, busy and done drop to 0 immediately; no done pulse; cmd_ready=1 after release. cmd_valid held high during busy -> accepted only after DONE.
